custom_ip_apb_regif: RTL and testbench
======================================

Name: custom_ip_apb_regif

Overview:
- Register-file side of the reg2ip/ip2reg hardware interface: the initiator/writer end that feeds per-channel write data and enables into a custom IP and captures the IP's returned status words.
- Exposes an APB slave so software can program control words and read back captured status.
- Sits between the peripheral APB interconnect and the custom IP instance.

Parameters:
- NUM_REGS, 3, number of channels (1..4).
- REG_WIDTH, 32, width of each control/status word.
- ADDR_WIDTH, 12, APB address bits decoded.
- HOLD_UNTIL_ACK, 0, 0: enable is a 1-cycle pulse; 1: enable held until acknowledged.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset.
- psel_i  in  1  APB select.
- penable_i  in  1  APB enable.
- pwrite_i  in  1  APB write.
- paddr_i  in  ADDR_WIDTH  APB address (byte).
- pwdata_i  in  REG_WIDTH  APB write data.
- prdata_o  out  REG_WIDTH  APB read data.
- pready_o  out  1  APB ready.
- pslverr_o  out  1  APB error.
- reg2ip_data_o  out  NUM_REGS*REG_WIDTH  control words; channel k at bits [(NUM_REGS-k)*REG_WIDTH-1 -: REG_WIDTH] (channel 0 in MSBs).
- reg2ip_en_o  out  NUM_REGS  per-channel write enable.
- reg2ip_ack_i  in  NUM_REGS  per-channel accept; used only when HOLD_UNTIL_ACK=1.
- ip2reg_data_i  in  NUM_REGS*(REG_WIDTH+1)  status; channel k at bits [(NUM_REGS-k)*(REG_WIDTH+1)-1 -: REG_WIDTH+1], value in upper REG_WIDTH bits, flag in LSB.
- ip2reg_en_i  in  NUM_REGS  per-channel status valid.

Behaviour:
- Clock is clk_i. Reset is rst_ni, asynchronous, active-low.
- Reset values: all outputs 0; shadow, status, pending, valid and flag registers 0; FSM in IDLE.
- Address map (word offsets):
  - 0x00+4k CTRLk, RW.
  - 0x10+4k STATk, RO.
  - 0x20 PEND, RO; bits[NUM_REGS-1:0] pending enables.
  - 0x24 SVALID; bits[NUM_REGS-1:0] valid (W1C), bits[8+k] captured flag (RO).
- APB FSM, states IDLE, SETUP, RESP:
  - IDLE -> SETUP on psel_i & !penable_i; latch addr, write and wdata.
  - SETUP -> RESP when psel_i & penable_i; decode and commit side effects on this transition.
  - RESP: pready_o=1, prdata_o/pslverr_o valid for exactly 1 cycle, then IDLE.
  - One wait state per transfer, so pready_o is high on the 2nd access cycle.
  - psel_i low while in SETUP: return to IDLE with no side effects.
  - prdata_o is 0 outside RESP.
- Errors: pslverr_o=1 with no side effects for an unmapped offset, paddr[1:0]!=0, or a write to STATk or PEND. Reads of unmapped offsets return 0.
- Write CTRLk: shadow[k]<=pwdata, pending[k]<=1. reg2ip_data_o is always the shadow registers, stable between writes.
- HOLD_UNTIL_ACK=0:
  - reg2ip_en_o[k]=1 for exactly the cycle after commit; pending self-clears.
- HOLD_UNTIL_ACK=1:
  - reg2ip_en_o[k]=pending[k]; cleared in the cycle after reg2ip_ack_i[k]=1.
  - Write while pending: data replaced, still pending.
  - Ack and commit in the same cycle: pending stays 1.
- Status capture:
  - When ip2reg_en_i[k]=1 and reg2ip_en_o==0: stat[k]<=value, flag[k]<=LSB, valid[k]<=1.
  - Capture is suppressed for all channels while any reg2ip_en_o bit is high.
- SVALID write: bits written 1 clear valid. If a capture occurs in the same cycle, set wins.
- Reset mid-transfer aborts the transfer; no partial commit.

Decomposition:
- Package custom_ip_regif_pkg: offset constants (CTRL_BASE, STAT_BASE, PEND_OFF, SVALID_OFF), FSM state enum, flag bit position 8.
- Sub-module custom_ip_regif_chan, one instance per channel: holds shadow, pending, status, flag and valid, and implements the enable and ack logic.

Test Plan:
- Write CTRL1=0xDEADBEEF, HOLD=0 -> 1-cycle pulse reg2ip_en_o=3'b010; reg2ip_data_o[63:32]=0xDEADBEEF; pready_o high on 2nd access cycle; pslverr_o=0.
- HOLD=1, write CTRL0=0x1234, ack delayed 5 cycles -> en[0] high for 5 cycles, clears 1 cycle after ack; PEND reads 0x1 before ack, 0x0 after. Second write 0x5678 in the same cycle as ack -> en[0] stays high.
- ip2reg_data_i={0x2468,0,0x369C,1,0x48D0,0} with ip2reg_en_i=3'b111 and no enables pending -> STAT0=0x2468, STAT1=0x369C, STAT2=0x48D0; SVALID=0x207. W1C 0x2 -> SVALID=0x205.
- Capture while reg2ip_en_o!=0 -> STAT unchanged. W1C of SVALID bit 0 in the same cycle as a capture on channel 0 -> valid stays 1.
- Write to 0x10, address 0x40, or address 0x02 -> pslverr_o=1, no state change; read of 0x40 returns 0.
- rst_ni asserted in SETUP of a CTRL2 write -> no enable pulse, shadow 0, all outputs 0; the next transfer completes normally.

Source files
------------

// File: rtl/custom_ip_regif_pkg.sv
`default_nettype none
// ============================================================================
// Module   : custom_ip_regif_pkg
// Purpose  : Shared offsets, FSM states and helpers for the custom IP APB regif
// Revision : 1.0 - initial release
// ============================================================================
package custom_ip_regif_pkg;

    localparam int CTRL_BASE  = 'h00;
    localparam int STAT_BASE  = 'h10;
    localparam int PEND_OFF   = 'h20;
    localparam int SVALID_OFF = 'h24;
    localparam int FLAG_BIT   = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_RESP  = 2'd2
    } apb_state_e;

    function automatic int reg_offset(input int base, input int idx);
        return base + 4 * idx;
    endfunction

endpackage : custom_ip_regif_pkg
`default_nettype wire

// File: rtl/custom_ip_regif_chan.sv
`default_nettype none
// ============================================================================
// Module   : custom_ip_regif_chan
// Purpose  : One reg2ip/ip2reg channel: control shadow, enable/ack, status
// Revision : 1.0 - initial release
// ============================================================================
module custom_ip_regif_chan
    import custom_ip_regif_pkg::*;
#(
    parameter int REG_WIDTH      = 32,
    parameter int HOLD_UNTIL_ACK = 0
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_wr,
    input  logic [REG_WIDTH-1:0] i_wdata,
    input  logic                 i_ack,
    input  logic                 i_cap,
    input  logic [REG_WIDTH-1:0] i_cap_data,
    input  logic                 i_cap_flag,
    input  logic                 i_clr,
    output logic [REG_WIDTH-1:0] o_shadow,
    output logic                 o_pending,
    output logic [REG_WIDTH-1:0] o_stat,
    output logic                 o_flag,
    output logic                 o_valid
);

    logic [REG_WIDTH-1:0] r_shadow;
    logic                 r_pending;
    logic [REG_WIDTH-1:0] r_stat;
    logic                 r_flag;
    logic                 r_valid;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shadow  <= '0;
            r_pending <= 1'b0;
            r_stat    <= '0;
            r_flag    <= 1'b0;
            r_valid   <= 1'b0;
        end else begin
            if (i_wr) begin
                r_shadow <= i_wdata;
            end
            // A commit beats a same-cycle ack so the new word is still offered.
            if (i_wr) begin
                r_pending <= 1'b1;
            end else if (HOLD_UNTIL_ACK == 0 || i_ack) begin
                r_pending <= 1'b0;
            end
            if (i_cap) begin
                r_stat  <= i_cap_data;
                r_flag  <= i_cap_flag;
                r_valid <= 1'b1;
            end else if (i_clr) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_shadow  = r_shadow;
    assign o_pending = r_pending;
    assign o_stat    = r_stat;
    assign o_flag    = r_flag;
    assign o_valid   = r_valid;

endmodule : custom_ip_regif_chan
`default_nettype wire

// File: rtl/custom_ip_apb_regif.sv
`default_nettype none
// ============================================================================
// Module   : custom_ip_apb_regif
// Purpose  : APB slave register file driving reg2ip words, capturing ip2reg
// Revision : 1.0 - initial release
// ============================================================================
module custom_ip_apb_regif
    import custom_ip_regif_pkg::*;
#(
    parameter int NUM_REGS       = 3,
    parameter int REG_WIDTH      = 32,
    parameter int ADDR_WIDTH     = 12,
    parameter int HOLD_UNTIL_ACK = 0
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              psel_i,
    input  logic                              penable_i,
    input  logic                              pwrite_i,
    input  logic [ADDR_WIDTH-1:0]             paddr_i,
    input  logic [REG_WIDTH-1:0]              pwdata_i,
    output logic [REG_WIDTH-1:0]              prdata_o,
    output logic                              pready_o,
    output logic                              pslverr_o,
    output logic [NUM_REGS*REG_WIDTH-1:0]     reg2ip_data_o,
    output logic [NUM_REGS-1:0]               reg2ip_en_o,
    input  logic [NUM_REGS-1:0]               reg2ip_ack_i,
    input  logic [NUM_REGS*(REG_WIDTH+1)-1:0] ip2reg_data_i,
    input  logic [NUM_REGS-1:0]               ip2reg_en_i
);

    apb_state_e              r_state;
    apb_state_e              w_state_nxt;
    logic                    w_pready;

    logic [ADDR_WIDTH-1:0]   r_addr;
    logic                    r_write;
    logic [REG_WIDTH-1:0]    r_wdata;
    logic [REG_WIDTH-1:0]    r_prdata;
    logic                    r_pslverr;

    logic                    w_commit;
    logic                    w_wr_ok;
    logic                    w_err;
    logic [REG_WIDTH-1:0]    w_rdata;
    logic [NUM_REGS-1:0]     w_ctrl_sel;
    logic                    w_svalid_sel;

    logic [REG_WIDTH-1:0]    w_shadow [NUM_REGS];
    logic [REG_WIDTH-1:0]    w_stat   [NUM_REGS];
    logic [NUM_REGS-1:0]     w_pending;
    logic [NUM_REGS-1:0]     w_flag;
    logic [NUM_REGS-1:0]     w_valid;
    logic [NUM_REGS-1:0]     w_cap;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pready    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (psel_i && !penable_i) begin
                    w_state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (!psel_i) begin
                    w_state_nxt = ST_IDLE;
                end else if (penable_i) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                w_pready    = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_commit = (r_state == ST_SETUP) && psel_i && penable_i;
    assign w_wr_ok  = w_commit && r_write && !w_err;

    // Decode runs on the request latched at the setup phase.
    always_comb begin
        w_err        = 1'b1;
        w_rdata      = '0;
        w_ctrl_sel   = '0;
        w_svalid_sel = 1'b0;
        if (r_addr[1:0] == 2'b00) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (r_addr == ADDR_WIDTH'(reg_offset(CTRL_BASE, k))) begin
                    w_err         = 1'b0;
                    w_rdata       = w_shadow[k];
                    w_ctrl_sel[k] = 1'b1;
                end
                if (r_addr == ADDR_WIDTH'(reg_offset(STAT_BASE, k))) begin
                    w_err   = r_write;
                    w_rdata = w_stat[k];
                end
            end
            if (r_addr == ADDR_WIDTH'(PEND_OFF)) begin
                w_err                   = r_write;
                w_rdata[NUM_REGS-1:0]   = w_pending;
            end
            if (r_addr == ADDR_WIDTH'(SVALID_OFF)) begin
                w_err                        = 1'b0;
                w_svalid_sel                 = 1'b1;
                w_rdata[NUM_REGS-1:0]        = w_valid;
                w_rdata[FLAG_BIT +: NUM_REGS] = w_flag;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_addr    <= '0;
            r_write   <= 1'b0;
            r_wdata   <= '0;
            r_prdata  <= '0;
            r_pslverr <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && psel_i && !penable_i) begin
                r_addr  <= paddr_i;
                r_write <= pwrite_i;
                r_wdata <= pwdata_i;
            end
            // Response registers are only non-zero for the single RESP cycle.
            r_pslverr <= w_commit && w_err;
            r_prdata  <= (w_commit && !r_write && !w_err) ? w_rdata : '0;
        end
    end

    assign pready_o  = w_pready;
    assign prdata_o  = r_prdata;
    assign pslverr_o = r_pslverr;

    // Any outstanding enable blocks status capture on every channel.
    assign w_cap       = ip2reg_en_i & {NUM_REGS{~|w_pending}};
    assign reg2ip_en_o = w_pending;

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_chan
        localparam int c_data_hi = (NUM_REGS - k) * REG_WIDTH - 1;
        localparam int c_stat_hi = (NUM_REGS - k) * (REG_WIDTH + 1) - 1;

        custom_ip_regif_chan #(
            .REG_WIDTH      (REG_WIDTH),
            .HOLD_UNTIL_ACK (HOLD_UNTIL_ACK)
        ) u_chan (
            .i_clk      (clk_i),
            .i_rst_n    (rst_ni),
            .i_wr       (w_wr_ok && w_ctrl_sel[k]),
            .i_wdata    (r_wdata),
            .i_ack      (reg2ip_ack_i[k]),
            .i_cap      (w_cap[k]),
            .i_cap_data (ip2reg_data_i[c_stat_hi -: REG_WIDTH]),
            .i_cap_flag (ip2reg_data_i[c_stat_hi - REG_WIDTH]),
            .i_clr      (w_wr_ok && w_svalid_sel && r_wdata[k]),
            .o_shadow   (w_shadow[k]),
            .o_pending  (w_pending[k]),
            .o_stat     (w_stat[k]),
            .o_flag     (w_flag[k]),
            .o_valid    (w_valid[k])
        );

        assign reg2ip_data_o[c_data_hi -: REG_WIDTH] = w_shadow[k];
    end

endmodule : custom_ip_apb_regif
`default_nettype wire

// File: tb/tb_custom_ip_apb_regif.sv
`default_nettype none
// ============================================================================
// Module   : tb_custom_ip_apb_regif
// Purpose  : Self-checking bench, pulse (HOLD=0) and hold (HOLD=1) instances
// Revision : 1.0 - initial release
// ============================================================================
module tb_custom_ip_apb_regif;

    localparam int N  = 3;
    localparam int W  = 32;
    localparam int AW = 12;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [1:0]        psel;
    logic              penable;
    logic              pwrite;
    logic [AW-1:0]     paddr;
    logic [W-1:0]      pwdata;
    logic [W-1:0]      prdata [2];
    logic [1:0]        pready;
    logic [1:0]        pslverr;
    logic [N*W-1:0]    r2i_data [2];
    logic [N-1:0]      r2i_en [2];
    logic [N-1:0]      ack;
    logic [N*(W+1)-1:0] i2r_data;
    logic [N-1:0]      i2r_en;

    int errors = 0;
    int checks = 0;

    // Transaction-level model of both instances (index 0: pulse, 1: hold).
    logic [W-1:0] m_shadow [2][N];
    logic [W-1:0] m_stat   [2][N];
    logic [N-1:0] m_flag   [2];
    logic [N-1:0] m_valid  [2];
    logic [N-1:0] m_pend   [2];

    logic [W-1:0] cap_val [N];
    logic [N-1:0] cap_flg;
    logic [AW-1:0] addrs [13];

    always #5 clk = ~clk;

    always_comb begin
        i2r_data = '0;
        for (int k = 0; k < N; k++) begin
            i2r_data[(N-k)*(W+1)-1 -: W+1] = {cap_val[k], cap_flg[k]};
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_dut
        custom_ip_apb_regif #(
            .NUM_REGS(N), .REG_WIDTH(W), .ADDR_WIDTH(AW), .HOLD_UNTIL_ACK(g)
        ) u_dut (
            .clk_i         (clk),
            .rst_ni        (rst_n),
            .psel_i        (psel[g]),
            .penable_i     (penable),
            .pwrite_i      (pwrite),
            .paddr_i       (paddr),
            .pwdata_i      (pwdata),
            .prdata_o      (prdata[g]),
            .pready_o      (pready[g]),
            .pslverr_o     (pslverr[g]),
            .reg2ip_data_o (r2i_data[g]),
            .reg2ip_en_o   (r2i_en[g]),
            .reg2ip_ack_i  (ack),
            .ip2reg_data_i (i2r_data),
            .ip2reg_en_i   (i2r_en)
        );
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < N; k++) begin
                m_shadow[d][k] = '0;
                m_stat[d][k]   = '0;
            end
            m_flag[d]  = '0;
            m_valid[d] = '0;
            m_pend[d]  = '0;
        end
    endtask

    // Capture happens only where no enable is outstanding; ack then clears.
    task automatic model_cycle(input logic [N-1:0] cap, input logic [N-1:0] ak);
        for (int d = 0; d < 2; d++) begin
            if (m_pend[d] == '0) begin
                for (int k = 0; k < N; k++) begin
                    if (cap[k]) begin
                        m_stat[d][k]  = cap_val[k];
                        m_flag[d][k]  = cap_flg[k];
                        m_valid[d][k] = 1'b1;
                    end
                end
            end
        end
        m_pend[1] = m_pend[1] & ~ak;
    endtask

    task automatic pulse(input logic [N-1:0] cap, input logic [N-1:0] ak);
        step();
        i2r_en = cap;
        ack    = ak;
        model_cycle(cap, ak);
        step();
        i2r_en = '0;
        ack    = '0;
    endtask

    task automatic xfer(input int d, input logic wr, input logic [AW-1:0] addr,
                        input logic [W-1:0] data, input logic [N-1:0] cap_c,
                        input logic [N-1:0] ack_c, output logic [W-1:0] rd,
                        output logic err);
        logic         exp_err;
        logic [W-1:0] exp_rd;
        logic [N-1:0] exp_en;
        logic         is_ctrl;
        int           a;
        int           n;
        a       = int'(addr);
        exp_err = 1'b1;
        exp_rd  = '0;
        is_ctrl = 1'b0;
        if (a % 4 == 0) begin
            if (a < 'h10 && a / 4 < N) begin
                exp_err = 1'b0;
                exp_rd  = m_shadow[d][a/4];
                is_ctrl = 1'b1;
            end else if (a >= 'h10 && a < 'h20 && (a - 'h10) / 4 < N) begin
                exp_err = wr;
                exp_rd  = m_stat[d][(a-'h10)/4];
            end else if (a == 'h20) begin
                exp_err = wr;
                exp_rd  = W'(m_pend[d]);
            end else if (a == 'h24) begin
                exp_err = 1'b0;
                exp_rd  = (W'(m_flag[d]) << 8) | W'(m_valid[d]);
            end
        end
        if (exp_err || wr) exp_rd = '0;

        step();
        psel[d] = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
        step();
        penable = 1'b1; i2r_en = cap_c; ack = ack_c;
        if (!exp_err && wr && a == 'h24) m_valid[d] = m_valid[d] & ~data[N-1:0];
        model_cycle(cap_c, ack_c);
        if (!exp_err && wr && is_ctrl) begin
            m_shadow[d][a/4] = data;
            if (d == 1) m_pend[1][a/4] = 1'b1;
        end
        exp_en = m_pend[d];
        if (d == 0 && !exp_err && wr && is_ctrl) exp_en[a/4] = 1'b1;

        @(negedge clk);
        checks++;
        if (pready[d] !== 1'b0) begin
            errors++; $display("FAIL pready_early d%0d: got %b expected 0", d, pready[d]);
        end
        step();
        i2r_en = '0; ack = '0;
        @(negedge clk);
        n = 0;
        while (pready[d] !== 1'b1 && n < 4) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != 0 || pready[d] !== 1'b1) begin
            errors++; $display("FAIL pready_2nd d%0d: got %b after %0d extra cycles expected 1 at once", d, pready[d], n);
        end
        rd  = prdata[d];
        err = pslverr[d];
        checks++;
        if (err !== exp_err) begin
            errors++; $display("FAIL pslverr d%0d a=%h: got %b expected %b", d, addr, err, exp_err);
        end
        if (!wr) begin
            checks++;
            if (rd !== exp_rd) begin
                errors++; $display("FAIL prdata d%0d a=%h: got %h expected %h", d, addr, rd, exp_rd);
            end
        end
        checks++;
        if (r2i_en[d] !== exp_en) begin
            errors++; $display("FAIL en_resp d%0d: got %b expected %b", d, r2i_en[d], exp_en);
        end
        step();
        psel[d] = 1'b0; penable = 1'b0;
        @(negedge clk);
        checks++;
        if (r2i_en[d] !== m_pend[d]) begin
            errors++; $display("FAIL en_after d%0d: got %b expected %b", d, r2i_en[d], m_pend[d]);
        end
        checks++;
        if (r2i_data[d] !== {m_shadow[d][0], m_shadow[d][1], m_shadow[d][2]}) begin
            errors++; $display("FAIL reg2ip_data d%0d: got %h expected %h", d, r2i_data[d],
                               {m_shadow[d][0], m_shadow[d][1], m_shadow[d][2]});
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        step();
        step();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({prdata[d], pready[d], pslverr[d], r2i_en[d]} !== '0 || r2i_data[d] !== '0) begin
                errors++; $display("FAIL reset_outputs d%0d: got prdata=%h rdy=%b err=%b en=%b data=%h expected all 0",
                                   d, prdata[d], pready[d], pslverr[d], r2i_en[d], r2i_data[d]);
            end
        end
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_ctrl_pulse();
        logic [W-1:0]   rd;
        logic           er;
        logic [N*W-1:0] dv;
        xfer(0, 1'b1, 12'h004, 32'hDEADBEEF, '0, '0, rd, er);
        dv = r2i_data[0];
        checks++;
        if (dv[63:32] !== 32'hDEADBEEF) begin
            errors++; $display("FAIL ctrl1_word: got %h expected deadbeef", dv[63:32]);
        end
    endtask

    task automatic test_hold_ack();
        logic [W-1:0] rd;
        logic         er;
        xfer(1, 1'b1, 12'h000, 32'h1234, '0, '0, rd, er);
        for (int i = 0; i < 5; i++) begin
            step();
            @(negedge clk);
            checks++;
            if (r2i_en[1][0] !== 1'b1) begin
                errors++; $display("FAIL hold_en cycle%0d: got %b expected 1", i, r2i_en[1][0]);
            end
        end
        xfer(1, 1'b0, 12'h020, '0, '0, '0, rd, er);
        checks++;
        if (rd !== 32'h1) begin
            errors++; $display("FAIL pend_before_ack: got %h expected 1", rd);
        end
        step();
        ack = 3'b001;
        @(negedge clk);
        checks++;
        if (r2i_en[1][0] !== 1'b1) begin
            errors++; $display("FAIL en_during_ack: got %b expected 1", r2i_en[1][0]);
        end
        step();
        ack = '0;
        m_pend[1][0] = 1'b0;
        @(negedge clk);
        checks++;
        if (r2i_en[1][0] !== 1'b0) begin
            errors++; $display("FAIL en_after_ack: got %b expected 0", r2i_en[1][0]);
        end
        xfer(1, 1'b0, 12'h020, '0, '0, '0, rd, er);
        checks++;
        if (rd !== 32'h0) begin
            errors++; $display("FAIL pend_after_ack: got %h expected 0", rd);
        end
        xfer(1, 1'b1, 12'h000, 32'h1111, '0, '0, rd, er);
        xfer(1, 1'b1, 12'h000, 32'h5678, '0, 3'b001, rd, er);
        checks++;
        if (r2i_en[1][0] !== 1'b1) begin
            errors++; $display("FAIL ack_commit_same_cycle: got %b expected 1", r2i_en[1][0]);
        end
        pulse('0, 3'b111);
    endtask

    task automatic test_capture();
        logic [W-1:0] rd;
        logic         er;
        cap_val[0] = 32'h2468; cap_val[1] = 32'h369C; cap_val[2] = 32'h48D0;
        cap_flg    = 3'b010;
        pulse(3'b111, '0);
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < N; k++) begin
                xfer(d, 1'b0, AW'('h10 + 4*k), '0, '0, '0, rd, er);
            end
            xfer(d, 1'b0, 12'h024, '0, '0, '0, rd, er);
            checks++;
            if (rd !== 32'h207) begin
                errors++; $display("FAIL svalid_after_cap d%0d: got %h expected 207", d, rd);
            end
        end
        xfer(0, 1'b1, 12'h024, 32'h2, '0, '0, rd, er);
        xfer(0, 1'b0, 12'h024, '0, '0, '0, rd, er);
        checks++;
        if (rd !== 32'h205) begin
            errors++; $display("FAIL svalid_w1c: got %h expected 205", rd);
        end
    endtask

    task automatic test_cap_suppress();
        logic [W-1:0] rd;
        logic         er;
        xfer(1, 1'b1, 12'h008, 32'hA5A5_0001, '0, '0, rd, er);
        cap_val[0] = 32'h1357; cap_val[1] = 32'h9BDF; cap_val[2] = 32'h0F0F;
        cap_flg    = 3'b101;
        pulse(3'b111, '0);
        xfer(1, 1'b0, 12'h010, '0, '0, '0, rd, er);
        checks++;
        if (rd !== 32'h2468) begin
            errors++; $display("FAIL stat_suppressed: got %h expected 2468", rd);
        end
        xfer(0, 1'b0, 12'h010, '0, '0, '0, rd, er);
        xfer(0, 1'b1, 12'h024, 32'h1, 3'b001, '0, rd, er);
        xfer(0, 1'b0, 12'h024, '0, '0, '0, rd, er);
        checks++;
        if (rd[0] !== 1'b1) begin
            errors++; $display("FAIL w1c_vs_capture: got %b expected 1", rd[0]);
        end
        pulse('0, 3'b111);
    endtask

    task automatic test_errors();
        logic [W-1:0] rd;
        logic         er;
        xfer(0, 1'b1, 12'h010, 32'hFFFF_FFFF, '0, '0, rd, er);
        xfer(0, 1'b1, 12'h040, 32'hFFFF_FFFF, '0, '0, rd, er);
        xfer(0, 1'b1, 12'h002, 32'hFFFF_FFFF, '0, '0, rd, er);
        checks++;
        if (er !== 1'b1) begin
            errors++; $display("FAIL misaligned_err: got %b expected 1", er);
        end
        xfer(0, 1'b0, 12'h040, '0, '0, '0, rd, er);
        checks++;
        if (rd !== '0 || er !== 1'b1) begin
            errors++; $display("FAIL unmapped_read: got %h/%b expected 0/1", rd, er);
        end
        xfer(1, 1'b1, 12'h020, 32'h7, '0, '0, rd, er);
    endtask

    task automatic test_random();
        logic [W-1:0] rd;
        logic         er;
        for (int i = 0; i < 80; i++) begin
            for (int k = 0; k < N; k++) cap_val[k] = $urandom;
            cap_flg = 3'($urandom_range(0, 7));
            xfer(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 addrs[$urandom_range(0, 12)], $urandom,
                 ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000,
                 ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000,
                 rd, er);
            if ($urandom_range(0, 2) == 0) begin
                pulse(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0]   rd;
        logic           er;
        logic [N*W-1:0] dv;
        step();
        psel[0] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h008; pwdata = 32'hCAFEF00D;
        step();
        penable = 1'b1;
        #2;
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        checks++;
        if ({prdata[0], pready[0], pslverr[0], r2i_en[0]} !== '0 || r2i_data[0] !== '0) begin
            errors++; $display("FAIL reset_mid_outputs: got rdy=%b en=%b data=%h expected all 0",
                               pready[0], r2i_en[0], r2i_data[0]);
        end
        step();
        psel[0] = 1'b0; penable = 1'b0;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (r2i_en[0] !== '0 || r2i_data[0] !== '0) begin
            errors++; $display("FAIL reset_mid_no_commit: got en=%b data=%h expected 0", r2i_en[0], r2i_data[0]);
        end
        xfer(0, 1'b1, 12'h008, 32'h600DF00D, '0, '0, rd, er);
        dv = r2i_data[0];
        checks++;
        if (dv[31:0] !== 32'h600DF00D) begin
            errors++; $display("FAIL after_reset_write: got %h expected 600df00d", dv[31:0]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        psel = '0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
        ack = '0; i2r_en = '0; cap_flg = '0;
        for (int k = 0; k < N; k++) cap_val[k] = '0;
        addrs[0] = 12'h000; addrs[1] = 12'h004; addrs[2]  = 12'h008; addrs[3]  = 12'h00C;
        addrs[4] = 12'h010; addrs[5] = 12'h014; addrs[6]  = 12'h018; addrs[7]  = 12'h01C;
        addrs[8] = 12'h020; addrs[9] = 12'h024; addrs[10] = 12'h040; addrs[11] = 12'h002;
        addrs[12] = 12'h026;
        test_reset();
        test_ctrl_pulse();
        test_hold_ack();
        test_capture();
        test_cap_suppress();
        test_errors();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_custom_ip_apb_regif
`default_nettype wire
